// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: groups the ID-stage operand/destination info, branch and
// memory back-pressure inputs, and the pipeline-control / status outputs of
// hazard_ctrl.
//   slave  : hazard_ctrl side (receives i_*, drives o_*)
//   master : pipeline side    (drives i_*, receives o_*)
interface hazard_ctrl_if;
  logic        i_id_vld;
  logic [4:0]  i_id_rs1_addr;
  logic [4:0]  i_id_rs2_addr;
  logic        i_id_rs1_used;
  logic        i_id_rs2_used;
  logic        i_id_rd_wren;
  logic [4:0]  i_id_rd_addr;
  logic        i_pc_sel_ex;
  logic        i_lsu_stall;
  logic        o_enable_pc;
  logic        o_enable_if;
  logic        o_enable_id;
  logic        o_enable_ex;
  logic        o_enable_mem;
  logic        o_reset_if;
  logic        o_reset_id;
  logic [1:0]  o_state;
  logic [31:0] o_stall_cnt;
  logic [31:0] o_flush_cnt;
  logic [31:0] o_freeze_cnt;

  modport slave (
    input  i_id_vld, i_id_rs1_addr, i_id_rs2_addr, i_id_rs1_used,
           i_id_rs2_used, i_id_rd_wren, i_id_rd_addr, i_pc_sel_ex, i_lsu_stall,
    output o_enable_pc, o_enable_if, o_enable_id, o_enable_ex, o_enable_mem,
           o_reset_if, o_reset_id, o_state, o_stall_cnt, o_flush_cnt,
           o_freeze_cnt
  );

  modport master (
    output i_id_vld, i_id_rs1_addr, i_id_rs2_addr, i_id_rs1_used,
           i_id_rs2_used, i_id_rd_wren, i_id_rd_addr, i_pc_sel_ex, i_lsu_stall,
    input  o_enable_pc, o_enable_if, o_enable_id, o_enable_ex, o_enable_mem,
           o_reset_if, o_reset_id, o_state, o_stall_cnt, o_flush_cnt,
           o_freeze_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard controller for a non-forwarding five-stage RV32I core.
// A three-entry destination scoreboard (EX, MEM, WB) detects RAW hazards on
// the ID instruction. Each cycle is classified FREEZE > FLUSH > STALL > RUN and
// the pipeline-register enables and active-low synchronous flushes are driven
// combinationally from that class. The class of the previous cycle and
// saturating per-class cycle counters are registered.
// Ports:
//   i_clk    : core clock, rising edge
//   i_reset  : asynchronous active-low reset
//   io_hz    : hazard_ctrl_if.slave (ID info, branch, LSU stall in;
//              enables, flushes, state, counters out)
module hazard_ctrl (
  input  logic         i_clk,
  input  logic         i_reset,
  hazard_ctrl_if.slave io_hz
);

  typedef enum logic [1:0] {
    CLS_RUN    = 2'd0,
    CLS_STALL  = 2'd1,
    CLS_FLUSH  = 2'd2,
    CLS_FREEZE = 2'd3
  } cls_e;

  logic        r_ex_vld, r_mem_vld, r_wb_vld;
  logic [4:0]  r_ex_rd,  r_mem_rd,  r_wb_rd;
  cls_e        r_state;
  logic [31:0] r_stall_cnt, r_flush_cnt, r_freeze_cnt;

  logic        w_rs1_hit, w_rs2_hit, w_hazard;
  cls_e        w_cls;
  logic        w_en_pc, w_en_if, w_en_id, w_en_ex, w_en_mem;
  logic        w_rst_if, w_rst_id;

  // WB entry still counts: the register file has no write-through bypass.
  always_comb begin
    w_rs1_hit = io_hz.i_id_rs1_used && (io_hz.i_id_rs1_addr != 5'd0) &&
                ((r_ex_vld  && (r_ex_rd  == io_hz.i_id_rs1_addr)) ||
                 (r_mem_vld && (r_mem_rd == io_hz.i_id_rs1_addr)) ||
                 (r_wb_vld  && (r_wb_rd  == io_hz.i_id_rs1_addr)));
    w_rs2_hit = io_hz.i_id_rs2_used && (io_hz.i_id_rs2_addr != 5'd0) &&
                ((r_ex_vld  && (r_ex_rd  == io_hz.i_id_rs2_addr)) ||
                 (r_mem_vld && (r_mem_rd == io_hz.i_id_rs2_addr)) ||
                 (r_wb_vld  && (r_wb_rd  == io_hz.i_id_rs2_addr)));
    w_hazard  = io_hz.i_id_vld && (w_rs1_hit || w_rs2_hit);
  end

  always_comb begin
    w_cls = CLS_RUN;
    if (io_hz.i_lsu_stall)      w_cls = CLS_FREEZE;
    else if (io_hz.i_pc_sel_ex) w_cls = CLS_FLUSH;
    else if (w_hazard)          w_cls = CLS_STALL;
  end

  always_comb begin
    w_en_pc  = 1'b1;
    w_en_if  = 1'b1;
    w_en_id  = 1'b1;
    w_en_ex  = 1'b1;
    w_en_mem = 1'b1;
    w_rst_if = 1'b1;
    w_rst_id = 1'b1;
    if (!i_reset) begin
      // Flush both front registers while reset is held.
      w_rst_if = 1'b0;
      w_rst_id = 1'b0;
    end else begin
      unique case (w_cls)
        CLS_FREEZE: begin
          w_en_pc  = 1'b0;
          w_en_if  = 1'b0;
          w_en_id  = 1'b0;
          w_en_ex  = 1'b0;
          w_en_mem = 1'b0;
        end
        CLS_FLUSH: begin
          w_rst_if = 1'b0;
          w_rst_id = 1'b0;
        end
        CLS_STALL: begin
          w_en_pc  = 1'b0;
          w_en_if  = 1'b0;
          w_rst_id = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Scoreboard shifts unless frozen; only a RUN cycle admits a new entry.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_ex_vld  <= 1'b0;
      r_mem_vld <= 1'b0;
      r_wb_vld  <= 1'b0;
      r_ex_rd   <= '0;
      r_mem_rd  <= '0;
      r_wb_rd   <= '0;
    end else if (w_cls != CLS_FREEZE) begin
      r_wb_vld  <= r_mem_vld;
      r_wb_rd   <= r_mem_rd;
      r_mem_vld <= r_ex_vld;
      r_mem_rd  <= r_ex_rd;
      r_ex_vld  <= (w_cls == CLS_RUN) && io_hz.i_id_vld && io_hz.i_id_rd_wren &&
                   (io_hz.i_id_rd_addr != 5'd0);
      r_ex_rd   <= io_hz.i_id_rd_addr;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= CLS_RUN;
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
      r_freeze_cnt <= '0;
    end else begin
      r_state <= w_cls;
      unique case (w_cls)
        CLS_STALL:  if (r_stall_cnt  != '1) r_stall_cnt  <= r_stall_cnt  + 32'd1;
        CLS_FLUSH:  if (r_flush_cnt  != '1) r_flush_cnt  <= r_flush_cnt  + 32'd1;
        CLS_FREEZE: if (r_freeze_cnt != '1) r_freeze_cnt <= r_freeze_cnt + 32'd1;
        default: ;
      endcase
    end
  end

  assign io_hz.o_enable_pc  = w_en_pc;
  assign io_hz.o_enable_if  = w_en_if;
  assign io_hz.o_enable_id  = w_en_id;
  assign io_hz.o_enable_ex  = w_en_ex;
  assign io_hz.o_enable_mem = w_en_mem;
  assign io_hz.o_reset_if   = w_rst_if;
  assign io_hz.o_reset_id   = w_rst_id;
  assign io_hz.o_state      = r_state;
  assign io_hz.o_stall_cnt  = r_stall_cnt;
  assign io_hz.o_flush_cnt  = r_flush_cnt;
  assign io_hz.o_freeze_cnt = r_freeze_cnt;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the non-forwarding five-stage RV32I core. It tracks destination registers of in-flight instructions in a three-entry scoreboard (EX, MEM, WB) and detects read-after-write hazards in ID. It drives the enables and active-low synchronous flushes of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, and resolves taken-branch flushes and data-memory back-pressure. Saturating performance counters record stall, flush and freeze cycles.

## Interface
- No parameters.
- i_clk  in  1  core clock, all state on rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_id_vld  in  1  IF/ID holds a valid instruction
- i_id_rs1_addr  in  5  rs1 index of ID instruction
- i_id_rs2_addr  in  5  rs2 index of ID instruction
- i_id_rs1_used  in  1  ID instruction reads rs1
- i_id_rs2_used  in  1  ID instruction reads rs2
- i_id_rd_wren  in  1  ID instruction writes rd
- i_id_rd_addr  in  5  rd index of ID instruction
- i_pc_sel_ex  in  1  taken branch/jump resolved in EX this cycle
- i_lsu_stall  in  1  data memory not ready; freeze pipeline
- o_enable_pc  out  1  PC update enable
- o_enable_if  out  1  IF/ID enable
- o_enable_id  out  1  ID/EX enable
- o_enable_ex  out  1  EX/MEM enable
- o_enable_mem  out  1  MEM/WB enable
- o_reset_if  out  1  active-low synchronous flush of IF/ID
- o_reset_id  out  1  active-low synchronous flush of ID/EX (inserts NOP 0x0000_0013)
- o_state  out  2  registered class of previous cycle: 0 RUN, 1 STALL, 2 FLUSH, 3 FREEZE
- o_stall_cnt  out  32  saturating STALL cycle count
- o_flush_cnt  out  32  saturating FLUSH cycle count
- o_freeze_cnt  out  32  saturating FREEZE cycle count

## Operation
- Scoreboard: entries sb_ex, sb_mem, sb_wb, each {vld, rd[4:0]}; vld set only if rd != 0.
- hazard = i_id_vld and ((i_id_rs1_used, rs1 != 0, rs1 matches any valid entry) or same for rs2). WB entry counts: register file has no write-through bypass.
- Cycle class, priority order, combinational from inputs and scoreboard:
  - FREEZE (i_lsu_stall=1): all five enables 0; both resets 1. Branch in EX is held and re-evaluated later.
  - FLUSH (i_pc_sel_ex=1): all enables 1; o_reset_if=0, o_reset_id=0. Wrong-path ID instruction never causes a stall.
  - STALL (hazard=1): o_enable_pc=0, o_enable_if=0; o_reset_id=0 (bubble); o_enable_id, o_enable_ex, o_enable_mem=1.
  - RUN: all enables 1; both resets 1.
- Scoreboard update at clock edge:
  - FREEZE holds all entries.
  - Otherwise sb_wb<=sb_mem and sb_mem<=sb_ex.
  - sb_ex<={i_id_vld and i_id_rd_wren and rd!=0, i_id_rd_addr} in RUN; invalid in STALL or FLUSH.
- o_state<=class; the matching counter increments by 1 and holds at 0xFFFF_FFFF.

## Timing
- Enables and resets are combinational, same cycle; o_state and counters lag one cycle.
- While i_reset=0: o_reset_if=0, o_reset_id=0, all enables 1, scoreboard invalid, o_state=0, counters 0. Outputs return to RUN values in the first cycle after release with no pending hazard.
- Back-to-back dependency (producer immediately followed by consumer): 3 STALL cycles; consumer enters EX on the 4th cycle.
- Dependency at distance 2 gives 2 STALL cycles; distance 3 gives 1; distance ≥4 gives 0.
- x0 never stalls.
- i_lsu_stall asserted during STALL: FREEZE overrides, scoreboard frozen, stall resumes after release with the same remaining count.
- Branch and hazard in the same cycle: FLUSH only; stall counter unchanged.
- Asynchronous reset mid-stall clears the scoreboard immediately; no residual stall.

## Test plan
- Reset: hold i_reset=0 for 3 cycles -> o_reset_if=o_reset_id=0, counters 0, o_state=0; release -> all enables 1, resets 1.
- RAW: addi x5 then add x6,x5,x1 back-to-back -> exactly 3 cycles with o_enable_pc=0, o_reset_id=0; o_stall_cnt=3.
- x0 and unused operands: producer writes x0, consumer reads x0; rs2_used=0 with matching rs2 -> no stall, o_stall_cnt=0.
- Taken branch while ID has a dependent instruction: i_pc_sel_ex=1 -> o_reset_if=0, o_reset_id=0, enables 1, o_flush_cnt=1, o_stall_cnt unchanged.
- Freeze mid-stall: after 1 stall cycle, i_lsu_stall=1 for 4 cycles -> all enables 0, o_freeze_cnt=4; on release, 2 more STALL cycles.
- Saturation: force o_stall_cnt to 0xFFFF_FFFE, apply 3 stall cycles -> o_stall_cnt reads 0xFFFF_FFFF.
